// File: rtl/dac_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dac_pkg: word size, frame length and silence value shared by the DAC path.
// Rev 1.0
// ---------------------------------------------------------------------------
package dac_pkg;

  localparam int DAC_WIDTH = 16;
  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 4;
  localparam logic [DAC_WIDTH-1:0] SILENCE_SAMPLE = 16'h0000;

  typedef logic [DAC_WIDTH-1:0] sample_t;

endpackage
`default_nettype wire

// File: rtl/dac_sample_feeder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dac_sample_feeder_if: valid/ready sample channel from the sound generators.
// Rev 1.0
// ---------------------------------------------------------------------------
interface dac_sample_feeder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_fifo: small register-array FIFO with explicit occupancy counter.
// Rev 1.0
// ---------------------------------------------------------------------------
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Level is tracked separately so full and empty stay distinct with wrapping pointers.
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign level    = level_q;

endmodule
`default_nettype wire

// File: rtl/dac_sample_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dac_sample_feeder: buffers samples and presents one per 16-clock DAC frame.
// Optional: UNDERRUN_COUNT_EN adds a saturating underrun_count output.
// Rev 1.0
// ---------------------------------------------------------------------------
module dac_sample_feeder
  import dac_pkg::*;
#(
  parameter int               WIDTH   = DAC_WIDTH,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] SILENCE = WIDTH'(SILENCE_SAMPLE)
) (
  input  logic                   clk,
  input  logic                   reset,
  dac_sample_feeder_if.slave     in_if,
  output logic [WIDTH-1:0]       sample_out,
  output logic                   frame_start,
  output logic [$clog2(DEPTH):0] level,
`ifdef UNDERRUN_COUNT_EN
  output logic [7:0]             underrun_count,
`endif
  output logic                   underrun
);
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic             underrun_q, underrun_d;
  logic             boundary;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_head;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_if.in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_comb begin
    boundary   = (bit_cnt_q == '0);
    bit_cnt_d  = bit_cnt_q - 1'b1;
    fifo_push  = in_if.in_valid && !fifo_full;
    // Pop decision uses the registered empty flag, so a same-cycle push cannot be popped.
    fifo_pop   = boundary && !fifo_empty;
    sample_d   = sample_q;
    underrun_d = 1'b0;
    if (boundary) begin
      sample_d   = fifo_empty ? SILENCE : fifo_head;
      underrun_d = fifo_empty;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q  <= '1;
      sample_q   <= SILENCE;
      underrun_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      sample_q   <= sample_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef UNDERRUN_COUNT_EN
  logic [7:0] underrun_cnt_q, underrun_cnt_d;

  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (underrun_d && (underrun_cnt_q != 8'hFF)) begin
      underrun_cnt_d = underrun_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underrun_cnt_q <= '0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  assign underrun_count = underrun_cnt_q;
`endif

  assign in_if.in_ready = !fifo_full;
  assign frame_start    = (bit_cnt_q == '1);
  assign sample_out     = sample_q;
  assign underrun       = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_feeder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dac_sample_feeder: directed vector table plus frame-level corner sequences.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dac_sample_feeder;
  import dac_pkg::*;

  logic       clk;
  logic       reset;
  sample_t    sample_out;
  logic       frame_start;
  logic [2:0] level;
  logic       underrun;
`ifdef UNDERRUN_COUNT_EN
  logic [7:0] underrun_count;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  dac_sample_feeder_if #(.WIDTH(16)) dif ();

  dac_sample_feeder #(
    .WIDTH   (16),
    .DEPTH   (4),
    .SILENCE (16'h0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_if          (dif),
    .sample_out     (sample_out),
    .frame_start    (frame_start),
    .level          (level),
`ifdef UNDERRUN_COUNT_EN
    .underrun_count (underrun_count),
`endif
    .underrun       (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          cyc;
    logic        vld;
    logic [15:0] dat;
    logic [15:0] e_so;
    logic        e_fs;
    logic [2:0]  e_lvl;
    logic        e_ur;
    logic        e_rdy;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  // Outputs are sampled and inputs driven on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset();
    dif.in_valid = 1'b0;
    dif.in_data  = 16'h0;
    reset        = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    logic [15:0] burst [5];

    tbl[0]  = '{0,  1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[1]  = '{1,  1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[2]  = '{2,  1'b1, 16'hA5A5, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[3]  = '{3,  1'b1, 16'h1234, 16'h0000, 1'b0, 3'd1, 1'b0, 1'b1};
    tbl[4]  = '{4,  1'b0, 16'h0000, 16'h0000, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[5]  = '{15, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd2, 1'b0, 1'b1};
    tbl[6]  = '{16, 1'b0, 16'h0000, 16'hA5A5, 1'b1, 3'd1, 1'b0, 1'b1};
    tbl[7]  = '{17, 1'b0, 16'h0000, 16'hA5A5, 1'b0, 3'd1, 1'b0, 1'b1};
    tbl[8]  = '{31, 1'b0, 16'h0000, 16'hA5A5, 1'b0, 3'd1, 1'b0, 1'b1};
    tbl[9]  = '{32, 1'b0, 16'h0000, 16'h1234, 1'b1, 3'd0, 1'b0, 1'b1};
    tbl[10] = '{47, 1'b0, 16'h0000, 16'h1234, 1'b0, 3'd0, 1'b0, 1'b1};
    tbl[11] = '{48, 1'b0, 16'h0000, 16'h0000, 1'b1, 3'd0, 1'b1, 1'b1};
    tbl[12] = '{49, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b1};

    burst[0] = 16'h1111; burst[1] = 16'h2222; burst[2] = 16'h3333;
    burst[3] = 16'h4444; burst[4] = 16'h5555;

    // Idle after reset: silence every frame, underrun at every boundary.
    do_reset();
    for (int k = 0; k <= 48; k++) begin
      check("idle sample_out", 32'(sample_out), 32'h0);
      check("idle frame_start", 32'(frame_start), 32'((k % 16) == 0));
      check("idle underrun", 32'(underrun), 32'((k % 16) == 0 && k > 0));
      tick();
    end

    // Two pushes early in the first frame, checked from the vector table.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      run_to(tbl[i].cyc);
      check("tbl sample_out", 32'(sample_out), 32'(tbl[i].e_so));
      check("tbl frame_start", 32'(frame_start), 32'(tbl[i].e_fs));
      check("tbl level", 32'(level), 32'(tbl[i].e_lvl));
      check("tbl underrun", 32'(underrun), 32'(tbl[i].e_ur));
      check("tbl in_ready", 32'(dif.in_ready), 32'(tbl[i].e_rdy));
      dif.in_valid = tbl[i].vld;
      dif.in_data  = tbl[i].dat;
      tick();
      dif.in_valid = 1'b0;
    end

    // Five back-to-back pushes into a depth-4 FIFO.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      check("burst in_ready", 32'(dif.in_ready), 32'h1);
      dif.in_valid = 1'b1;
      dif.in_data  = burst[k];
      tick();
    end
    dif.in_data = burst[4];
    check("full level", 32'(level), 32'd4);
    while (cyc < 16) begin
      check("full in_ready", 32'(dif.in_ready), 32'h0);
      tick();
    end
    check("pop frees slot in_ready", 32'(dif.in_ready), 32'h1);
    check("pop level", 32'(level), 32'd3);
    check("first sample", 32'(sample_out), 32'(burst[0]));
    check("no underrun burst", 32'(underrun), 32'h0);
    tick();
    dif.in_valid = 1'b0;
    check("held sample accepted level", 32'(level), 32'd4);
    check("refull in_ready", 32'(dif.in_ready), 32'h0);
    for (int j = 1; j <= 4; j++) begin
      run_to(16 + 16 * j);
      check("burst order", 32'(sample_out), 32'(burst[j]));
      check("burst level", 32'(level), 32'(4 - j));
      check("burst underrun", 32'(underrun), 32'h0);
    end
    run_to(96);
    check("drained sample_out", 32'(sample_out), 32'h0);
    check("drained underrun", 32'(underrun), 32'h1);

    // Push into an empty FIFO exactly on a boundary cycle.
    do_reset();
    run_to(15);
    dif.in_valid = 1'b1;
    dif.in_data  = 16'hBEEF;
    tick();
    dif.in_valid = 1'b0;
    check("edge push underrun", 32'(underrun), 32'h1);
    check("edge push sample_out", 32'(sample_out), 32'h0);
    check("edge push level", 32'(level), 32'd1);
    tick();
    check("edge push underrun drops", 32'(underrun), 32'h0);
    run_to(32);
    check("edge push delivered", 32'(sample_out), 32'hBEEF);
    check("edge push no underrun", 32'(underrun), 32'h0);
    check("edge push level after", 32'(level), 32'd0);

    // Asynchronous reset in the middle of a frame with three samples queued.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      dif.in_valid = 1'b1;
      dif.in_data  = burst[k];
      tick();
    end
    dif.in_valid = 1'b0;
    run_to(24);
    check("pre-reset level", 32'(level), 32'd3);
    check("pre-reset sample_out", 32'(sample_out), 32'(burst[0]));
    #2 reset = 1'b1;
    #1;
    check("async reset level", 32'(level), 32'd0);
    check("async reset sample_out", 32'(sample_out), 32'h0);
    check("async reset frame_start", 32'(frame_start), 32'h1);
    check("async reset in_ready", 32'(dif.in_ready), 32'h1);
    check("async reset underrun", 32'(underrun), 32'h0);
    do_reset();
    run_to(16);
    check("post-reset discarded", 32'(sample_out), 32'h0);
    check("post-reset underrun", 32'(underrun), 32'h1);

`ifdef UNDERRUN_COUNT_EN
    do_reset();
    check("count reset", 32'(underrun_count), 32'h0);
    run_to(16);
    check("count first", 32'(underrun_count), 32'h1);
    run_to(16 * 300 + 1);
    check("count saturated", 32'(underrun_count), 32'hFF);
    run_to(16 * 301 + 1);
    check("count stays saturated", 32'(underrun_count), 32'hFF);
    reset = 1'b1;
    #1;
    check("count cleared", 32'(underrun_count), 32'h0);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
